// File: rtl/dec_bcd_entry_reg.sv
// -----------------------------------------------------------------------------
// dec_bcd_entry_reg
//
// Keypad entry block. Ten decimal key lines (one line per key) are sampled once
// per clock and debounced. Each accepted press is encoded to a BCD digit and
// shifted into a DIGITS-deep BCD entry register. The result feeds the
// arithmetic and comparator blocks downstream.
//
// A press is accepted after the same non-zero pattern has been seen for
// STABLE_CYCLES consecutive samples. Only one digit is produced per press: the
// key must be fully released (all lines low) before another press can be
// accepted.
//
// If more than one line is high:
//   MULTI_MODE = 0 : the highest-index key wins, and multi_err pulses with the
//                    digit.
//   MULTI_MODE = 1 : the press is dropped. multi_err pulses and nothing is
//                    stored.
//
// Parameters
//   DIGITS         number of BCD digits in the entry register (>= 1)
//   STABLE_CYCLES  matching samples needed to accept a press (>= 2)
//   MULTI_MODE     multi-hot policy, see above
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; beats clear and all activity
//   d            decimal key lines, d[i] = key i
//   clear        synchronous clear of bcd_value, count and overflow
//                (the debounce FSM keeps running)
//   bcd_digit    BCD code of the last accepted digit
//   digit_valid  1-cycle pulse: bcd_digit and bcd_value updated this cycle
//   multi_err    1-cycle pulse: the accepted or rejected pattern was multi-hot
//   bcd_value    entry register, [3:0] = newest digit
//   count        number of digits held; saturates at DIGITS
//   overflow     sticky: a digit has been shifted out of the top position
//   fsm_state    debounce FSM state (0 idle, 1 debounce, 2 held)
// -----------------------------------------------------------------------------
module dec_bcd_entry_reg #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int MULTI_MODE    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     d,
    input  logic                           clear,
    output logic [3:0]                     bcd_digit,
    output logic                           digit_valid,
    output logic                           multi_err,
    output logic [4*DIGITS-1:0]            bcd_value,
    output logic [$clog2(DIGITS+1)-1:0]    count,
    output logic                           overflow,
    output logic [1:0]                     fsm_state
);

    localparam int VW    = 4 * DIGITS;
    localparam int CW    = $clog2(DIGITS + 1);
    localparam int CNT_W = $clog2(STABLE_CYCLES);

    localparam logic [CW-1:0]    COUNT_MAX = CW'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [9:0]       d_r;
    logic [9:0]       pattern;
    logic [9:0]       pattern_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    logic [3:0]       code;
    logic             multi_hot;
    logic             take_digit;
    logic [VW-1:0]    shifted;

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Input sample register and FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r     <= '0;
            state   <= ST_IDLE;
            pattern <= '0;
            cnt     <= '0;
        end else begin
            d_r     <= d;
            state   <= state_nxt;
            pattern <= pattern_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Debounce next-state logic. It only looks at the registered sample
    // d_r, never at the raw d lines.
    // cnt holds how many consecutive samples have matched pattern. A press
    // is accepted on the sample that brings the run to STABLE_CYCLES.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        cnt_nxt     = cnt;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_r != '0) begin
                    state_nxt   = ST_DEBOUNCE;
                    pattern_nxt = d_r;
                    cnt_nxt     = CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (d_r == '0) begin
                    state_nxt = ST_IDLE;
                end else if (d_r != pattern) begin
                    // The pattern changed before it settled: restart the
                    // run with the new pattern.
                    pattern_nxt = d_r;
                    cnt_nxt     = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    accept    = 1'b1;
                    state_nxt = ST_HELD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                // Only a full release re-arms the FSM. Any change while
                // the key is still down is ignored.
                if (d_r == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Encoder: the highest set line gives the code. The loop runs upward,
    // so the last assignment (the highest index) wins.
    // ------------------------------------------------------------------
    always_comb begin
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pattern[i]) begin
                code = 4'(i);
            end
        end
    end

    // x & (x - 1) clears the lowest set bit. Any bit left means more than
    // one line was high.
    assign multi_hot  = |(pattern & (pattern - 10'd1));
    assign take_digit = accept && !(multi_hot && (MULTI_MODE != 0));

    generate
        if (DIGITS == 1) begin : g_single
            assign shifted = VW'(code);
        end else begin : g_multi
            assign shifted = {bcd_value[VW-5:0], code};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Entry register and status outputs. When clear and an accepted digit
    // arrive in the same cycle, the register restarts with just that digit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_digit   <= 4'd0;
            digit_valid <= 1'b0;
            multi_err   <= 1'b0;
            bcd_value   <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            multi_err   <= accept && multi_hot;

            if (clear) begin
                bcd_value <= '0;
                count     <= '0;
                overflow  <= 1'b0;
            end

            if (take_digit) begin
                bcd_digit   <= code;
                digit_valid <= 1'b1;
                if (clear) begin
                    bcd_value <= VW'(code);
                    count     <= CW'(1);
                end else begin
                    bcd_value <= shifted;
                    if (count == COUNT_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dec_bcd_entry_reg.sv
module tb_dec_bcd_entry_reg;

    localparam int NDIG = 4;
    localparam int S    = 3;
    localparam int CW   = $clog2(NDIG + 1);
    localparam longint VMOD = 64'd1 << (4 * NDIG);

    // ------------------------------------------------------------------
    // Clock / reset / DUT signals
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    logic [9:0] d;
    logic clear;

    logic [3:0]       bcd_digit0,   bcd_digit1;
    logic             digit_valid0, digit_valid1;
    logic             multi_err0,   multi_err1;
    logic [4*NDIG-1:0] bcd_value0,  bcd_value1;
    logic [CW-1:0]    count0,       count1;
    logic             overflow0,    overflow1;
    logic [1:0]       fsm_state0,   fsm_state1;

    always #5 clk = ~clk;

    dec_bcd_entry_reg #(.DIGITS(NDIG), .STABLE_CYCLES(S), .MULTI_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .d(d), .clear(clear),
        .bcd_digit(bcd_digit0), .digit_valid(digit_valid0), .multi_err(multi_err0),
        .bcd_value(bcd_value0), .count(count0), .overflow(overflow0),
        .fsm_state(fsm_state0)
    );

    dec_bcd_entry_reg #(.DIGITS(NDIG), .STABLE_CYCLES(S), .MULTI_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .d(d), .clear(clear),
        .bcd_digit(bcd_digit1), .digit_valid(digit_valid1), .multi_err(multi_err1),
        .bcd_value(bcd_value1), .count(count1), .overflow(overflow1),
        .fsm_state(fsm_state1)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    int dv_count0 = 0;
    int dv_count1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits n falling edges; results are sampled 1 ns later.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A press is accepted on an edge when the last S
    // samples the debouncer has seen are the same non-zero pattern, and no
    // press has been accepted since the last all-zero sample. The entry
    // register is modelled as a base-16 number truncated to NDIG digits.
    // Index 0 models MULTI_MODE=0, index 1 models MULTI_MODE=1.
    // ------------------------------------------------------------------
    logic [9:0] m_dr;
    logic [9:0] hist[$];
    bit         m_held;
    bit         m_live = 1'b0;
    longint     mval[2];
    int         mcnt[2];
    bit         movf[2];
    int         mdig[2];
    bit         mdv[2];
    bit         mme[2];

    function automatic int hi_idx(input logic [9:0] v);
        int r = 0;
        for (int i = 0; i < 10; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        logic [9:0] seen;
        bit acc;
        bit same;
        bit multi;
        int code;
        if (rst) begin
            m_dr = '0;
            hist.delete();
            m_held = 1'b0;
            for (int m = 0; m < 2; m++) begin
                mval[m] = 0; mcnt[m] = 0; movf[m] = 0;
                mdig[m] = 0; mdv[m] = 0; mme[m] = 0;
            end
            m_live = 1'b1;
        end else begin
            seen = m_dr;
            hist.push_back(seen);
            if (hist.size() > S) void'(hist.pop_front());
            acc = 1'b0;
            if (seen == 10'd0) begin
                m_held = 1'b0;
            end else if (!m_held && hist.size() == S) begin
                same = 1'b1;
                foreach (hist[i]) if (hist[i] != seen) same = 1'b0;
                if (same) begin
                    acc = 1'b1;
                    m_held = 1'b1;
                end
            end
            m_dr  = d;
            code  = hi_idx(seen);
            multi = ($countones(seen) > 1);
            for (int m = 0; m < 2; m++) begin
                mdv[m] = 1'b0;
                mme[m] = 1'b0;
                if (clear) begin
                    mval[m] = 0; mcnt[m] = 0; movf[m] = 1'b0;
                end
                if (acc) begin
                    if (multi) mme[m] = 1'b1;
                    if (!(multi && m == 1)) begin
                        if (mcnt[m] == NDIG) movf[m] = 1'b1;
                        mval[m] = (mval[m] * 16 + longint'(code)) % VMOD;
                        mcnt[m] = (mcnt[m] < NDIG) ? mcnt[m] + 1 : NDIG;
                        mdig[m] = code;
                        mdv[m]  = 1'b1;
                    end
                end
            end
        end
    end

    // Every cycle, compare both DUTs against the model (away from the rising edge).
    always @(negedge clk) begin
        if (digit_valid0) dv_count0++;
        if (digit_valid1) dv_count1++;
        if (m_live) begin
            chk("m0.bcd_digit",   32'(bcd_digit0),   32'(mdig[0]));
            chk("m0.digit_valid", 32'(digit_valid0), 32'(mdv[0]));
            chk("m0.multi_err",   32'(multi_err0),   32'(mme[0]));
            chk("m0.bcd_value",   32'(bcd_value0),   32'(mval[0]));
            chk("m0.count",       32'(count0),       32'(mcnt[0]));
            chk("m0.overflow",    32'(overflow0),    32'(movf[0]));
            chk("m1.bcd_digit",   32'(bcd_digit1),   32'(mdig[1]));
            chk("m1.digit_valid", 32'(digit_valid1), 32'(mdv[1]));
            chk("m1.multi_err",   32'(multi_err1),   32'(mme[1]));
            chk("m1.bcd_value",   32'(bcd_value1),   32'(mval[1]));
            chk("m1.count",       32'(count1),       32'(mcnt[1]));
            chk("m1.overflow",    32'(overflow1),    32'(movf[1]));
        end
    end

    // ------------------------------------------------------------------
    // Vector table for the digit entry sequence
    // ------------------------------------------------------------------
    typedef struct {
        logic [9:0]  pat;
        int          hold;
        logic [15:0] exp_val;
        int          exp_cnt;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[5];

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int first;
        int dv_before;
        int hit;

        vecs[0] = '{pat: 10'h002, hold: 5, exp_val: 16'h0001, exp_cnt: 1, exp_ovf: 1'b0};
        vecs[1] = '{pat: 10'h004, hold: 6, exp_val: 16'h0012, exp_cnt: 2, exp_ovf: 1'b0};
        vecs[2] = '{pat: 10'h008, hold: 8, exp_val: 16'h0123, exp_cnt: 3, exp_ovf: 1'b0};
        vecs[3] = '{pat: 10'h010, hold: 4, exp_val: 16'h1234, exp_cnt: 4, exp_ovf: 1'b0};
        vecs[4] = '{pat: 10'h020, hold: 7, exp_val: 16'h2345, exp_cnt: 4, exp_ovf: 1'b1};

        // 1: reset with key 9 held, then accept after release of rst
        rst = 1'b1; clear = 1'b0; d = 10'h200;
        cyc(3);
        chk("rst.bcd_value0",  32'(bcd_value0),  32'h0);
        chk("rst.count0",      32'(count0),      32'h0);
        chk("rst.overflow0",   32'(overflow0),   32'h0);
        chk("rst.dv0",         32'(digit_valid0), 32'h0);
        chk("rst.bcd_digit1",  32'(bcd_digit1),  32'h0);
        chk("rst.fsm_state0",  32'(fsm_state0),  32'h0);
        rst = 1'b0;
        first = 0;
        for (int n = 1; n <= 8; n++) begin
            cyc(1);
            if (digit_valid0 && first == 0) first = n;
        end
        chk("rst.first_dv_cycle", 32'(first), 32'(S + 1));
        chk("rst.bcd_digit9",     32'(bcd_digit0), 32'h9);
        chk("rst.one_digit",      32'(dv_count0),  32'h1);
        d = 10'h000; cyc(3);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clr1.bcd_value0", 32'(bcd_value0), 32'h0);

        // 2/3: entry 1,2,3,4 then overflow with 5
        for (int i = 0; i < 5; i++) begin
            dv_before = dv_count0;
            d = vecs[i].pat;
            cyc(vecs[i].hold);
            d = 10'h000;
            cyc(4);
            chk("tbl.bcd_value", 32'(bcd_value0), 32'(vecs[i].exp_val));
            chk("tbl.count",     32'(count0),     32'(vecs[i].exp_cnt));
            chk("tbl.overflow",  32'(overflow0),  32'(vecs[i].exp_ovf));
            chk("tbl.one_pulse", 32'(dv_count0 - dv_before), 32'h1);
        end
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clr2.bcd_value", 32'(bcd_value0), 32'h0);
        chk("clr2.count",     32'(count0),     32'h0);
        chk("clr2.overflow",  32'(overflow0),  32'h0);

        // 4: bounce, then a pattern change mid-debounce
        dv_before = dv_count0;
        for (int i = 0; i < 10; i++) begin
            d = (i % 2 == 0) ? 10'h008 : 10'h000;
            cyc(1);
        end
        d = 10'h000; cyc(4);
        chk("bounce.no_digit", 32'(dv_count0 - dv_before), 32'h0);
        d = 10'h008; cyc(2);
        d = 10'h010; cyc(6);
        d = 10'h000; cyc(4);
        chk("switch.one_digit", 32'(dv_count0 - dv_before), 32'h1);
        chk("switch.digit4",    32'(bcd_digit0), 32'h4);

        // 5: multi-hot, keys 5 and 7 together
        d = 10'h0A0;
        hit = 0;
        for (int n = 0; n < 10 && hit == 0; n++) begin
            cyc(1);
            if (multi_err0) begin
                hit = 1;
                chk("mh.dv0_with_err", 32'(digit_valid0), 32'h1);
                chk("mh.digit7",       32'(bcd_digit0),   32'h7);
                chk("mh.err1",         32'(multi_err1),   32'h1);
                chk("mh.dv1_none",     32'(digit_valid1), 32'h0);
            end
        end
        chk("mh.seen", 32'(hit), 32'h1);
        d = 10'h000; cyc(4);
        chk("mh.value0",  32'(bcd_value0), 32'h0047);
        chk("mh.value1",  32'(bcd_value1), 32'h0004);
        chk("mh.digit1",  32'(bcd_digit1), 32'h4);

        // 6: long hold gives one digit
        dv_before = dv_count0;
        d = 10'h004; cyc(50);
        d = 10'h000; cyc(4);
        chk("hold.one_digit", 32'(dv_count0 - dv_before), 32'h1);
        chk("hold.value0",    32'(bcd_value0), 32'h0472);

        // clear on the accept edge of key 6
        d = 10'h040; cyc(3);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clracc.value0", 32'(bcd_value0),   32'h0006);
        chk("clracc.count0", 32'(count0),       32'h1);
        chk("clracc.dv0",    32'(digit_valid0), 32'h1);
        chk("clracc.value1", 32'(bcd_value1),   32'h0006);
        d = 10'h000; cyc(4);

        // rst during debounce
        dv_before = dv_count0;
        d = 10'h100; cyc(2);
        rst = 1'b1; cyc(1);
        rst = 1'b0; d = 10'h000;
        chk("rstdb.fsm_idle", 32'(fsm_state0), 32'h0);
        chk("rstdb.value0",   32'(bcd_value0), 32'h0);
        cyc(6);
        chk("rstdb.no_digit", 32'(dv_count0 - dv_before), 32'h0);

        // Random phase, checked by the model every cycle
        for (int k = 0; k < 80; k++) begin
            int kind;
            int hold;
            kind = $urandom_range(0, 9);
            if (kind < 6)      d = 10'(1 << $urandom_range(0, 9));
            else if (kind < 8) d = 10'($urandom_range(1, 1023));
            else               d = 10'h000;
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) begin
                clear = ($urandom_range(0, 19) == 0);
                rst   = ($urandom_range(0, 59) == 0);
                cyc(1);
            end
        end
        rst = 1'b0; clear = 1'b0; d = 10'h000;
        cyc(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
